// File: rtl/mem_access_unit.sv
// Purpose: load/store stage in front of a word-wide data memory with no byte strobes.
// Latency: acceptance to rsp_valid is 1 (error), 2 (load, word store) or 3 (sub-word store) cycles.
// Backpressure: req_ready only in IDLE, so one request is in flight at a time. The response is a pulse that cannot stall.
//
// Ports:
//   CLK, RSTn        - clock (rising edge) and asynchronous active-low reset
//   req_*            - request from execute: valid/ready, we, size, unsigned, byte addr, wdata, rd
//   rsp_*            - one-cycle completion: valid pulse; rdata, rd and err hold until the next response
//   mem_addr/mem_din - word index and write data to the memory; both hold their value between accesses
//   mem_dout         - combinational read data from the memory
//   mem_wr_n/mem_rd_n- active-low strobes, asserted only in WRITE / READ
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 5
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_din,
    input  logic [XLEN-1:0]   mem_dout,
    output logic              mem_wr_n,
    output logic              mem_rd_n
);

    // Memory strobes are active low.
    localparam logic WRITE_ENABLE  = 1'b0;
    localparam logic WRITE_DISABLE = 1'b1;
    localparam logic READ_ENABLE   = 1'b0;
    localparam logic READ_DISABLE  = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request fields latched at acceptance.
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [4:0]  rd_q;

    logic            req_err;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] merged;

    // Address bits above the memory depth are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[XLEN-1:MEM_AW+2];

    // Alignment and size check, evaluated on the live request in IDLE.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            SZ_BAD:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Lane extraction and extension for loads.
    always_comb begin
        byte_sel = mem_dout[{lane_q, 3'b000} +: 8];
        half_sel = mem_dout[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: load_ext = {{(XLEN-8){~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{(XLEN-16){~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_dout;
        endcase
    end

    // Read-merge for sub-word stores: only the addressed lane is replaced.
    always_comb begin
        merged = mem_dout;
        case (size_q)
            SZ_BYTE: merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
            SZ_HALF: merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            default: merged = mem_dout;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from state so an async reset drops them
    // immediately, which is what aborts an in-flight write.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd_n  = READ_DISABLE;
        mem_wr_n  = WRITE_DISABLE;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = S_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_rd_n  = READ_ENABLE;
                state_nxt = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                mem_wr_n  = WRITE_ENABLE;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath. rsp_* are only written on the edge entering RESP so they
    // keep the previous response until the next one is produced.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
            rd_q      <= '0;
            rsp_rdata <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        rd_q    <= req_rd;
                        if (req_err) begin
                            rsp_rdata <= '0;
                            rsp_rd    <= req_rd;
                            rsp_err   <= 1'b1;
                        end else begin
                            // Error requests leave the memory port untouched.
                            mem_addr <= req_addr[MEM_AW+1:2];
                            if (req_we && (req_size == SZ_WORD)) begin
                                mem_din <= req_wdata;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (we_q) begin
                        mem_din <= merged;
                    end else begin
                        rsp_rdata <= load_ext;
                        rsp_rd    <= rd_q;
                        rsp_err   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    rsp_rdata <= '0;
                    rsp_rd    <= rd_q;
                    rsp_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        CLK;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_wr_n;
    logic        mem_rd_n;

    mem_access_unit #(.XLEN(32), .MEM_AW(5)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_rd       (rsp_rd),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_wr_n     (mem_wr_n),
        .mem_rd_n     (mem_rd_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: combinational read, write on the rising edge.
    logic [31:0] mem [32];
    logic        mem_clr;
    assign mem_dout = mem[mem_addr];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int w = 0; w < 32; w++) mem[w] <= 32'h0;
        end else if (!mem_wr_n) begin
            mem[mem_addr] <= mem_din;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory as a flat byte array: 32 words = 128 bytes, little endian.
    logic [7:0] ref_bytes [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: byte-granular access rules.
    task automatic model(input vec_t r, output logic [31:0] rdata, output logic err, output int lat);
        int n;
        int base;
        logic [31:0] v;
        n     = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        err   = (r.size == 2'd3) || ((int'(r.addr[1:0]) % n) != 0);
        rdata = 32'h0;
        lat   = 1;
        if (!err) begin
            base = int'(r.addr[6:0]);
            if (r.we) begin
                for (int i = 0; i < n; i++) ref_bytes[base + i] = r.wdata[8*i +: 8];
                lat = (n == 4) ? 2 : 3;
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8*i));
                if (!r.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rdata = v;
                lat   = 2;
            end
        end
    endtask

    // Drive one request, wait for its response and the cycle after it.
    task automatic issue(input vec_t r, output int lat, output logic [31:0] rdata,
                         output logic err, output logic [4:0] rd, output logic strobe,
                         output logic post_valid, output logic [31:0] post_rdata);
        int waitc;
        waitc = 0;
        lat = 0; rdata = 32'h0; err = 1'b0; rd = 5'h0; strobe = 1'b0;
        post_valid = 1'b0; post_rdata = 32'h0;
        @(negedge CLK);
        while (!req_ready && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'h1);
        end else begin
            req_we = r.we; req_size = r.size; req_unsigned = r.uns;
            req_addr = r.addr; req_wdata = r.wdata; req_rd = r.rd;
            req_valid = 1'b1;
            @(posedge CLK);
            #1 req_valid = 1'b0;
            do begin
                @(negedge CLK);
                lat++;
                if (!mem_rd_n || !mem_wr_n) strobe = 1'b1;
            end while (!rsp_valid && lat < 10);
            if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'h1);
            rdata = rsp_rdata; err = rsp_err; rd = rsp_rd;
            @(negedge CLK);
            post_valid = rsp_valid;
            post_rdata = rsp_rdata;
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        int          lat, m_lat;
        logic [31:0] rdata, m_rdata, post_rdata;
        logic        err, m_err, strobe, post_valid;
        logic [4:0]  rd;
        vec_t        r;
        int          bad;

        // Table: we, size, uns, addr, wdata, rd, exp_rdata, exp_err, exp_lat
        tbl[0]  = mkv(1, 2'd2, 0, 32'h10,        32'hDEAD_BEEF, 5'd1,  32'h0,         0, 2);
        tbl[1]  = mkv(1, 2'd0, 0, 32'h13,        32'h0000_005A, 5'd2,  32'h0,         0, 3);
        tbl[2]  = mkv(0, 2'd2, 0, 32'h10,        32'h0,         5'd3,  32'h5AAD_BEEF, 0, 2);
        tbl[3]  = mkv(0, 2'd1, 0, 32'h12,        32'h0,         5'd4,  32'h0000_5AAD, 0, 2);
        tbl[4]  = mkv(0, 2'd1, 0, 32'h10,        32'h0,         5'd5,  32'hFFFF_BEEF, 0, 2);
        tbl[5]  = mkv(0, 2'd0, 1, 32'h10,        32'h0,         5'd6,  32'h0000_00EF, 0, 2);
        tbl[6]  = mkv(0, 2'd0, 0, 32'h11,        32'h0,         5'd7,  32'hFFFF_FFBE, 0, 2);
        tbl[7]  = mkv(0, 2'd1, 1, 32'h10,        32'h0,         5'd8,  32'h0000_BEEF, 0, 2);
        tbl[8]  = mkv(0, 2'd0, 0, 32'h13,        32'h0,         5'd9,  32'h0000_005A, 0, 2);
        tbl[9]  = mkv(0, 2'd2, 0, 32'h11,        32'h0,         5'd10, 32'h0,         1, 1);
        tbl[10] = mkv(0, 2'd3, 0, 32'h10,        32'h0,         5'd11, 32'h0,         1, 1);
        tbl[11] = mkv(1, 2'd1, 0, 32'h13,        32'h0000_FFFF, 5'd12, 32'h0,         1, 1);
        tbl[12] = mkv(1, 2'd1, 0, 32'h12,        32'h0000_1234, 5'd13, 32'h0,         0, 3);
        tbl[13] = mkv(0, 2'd2, 0, 32'h90,        32'h0,         5'd14, 32'h1234_BEEF, 0, 2);
        tbl[14] = mkv(1, 2'd0, 0, 32'hFFFF_FF91, 32'h0000_0099, 5'd15, 32'h0,         0, 3);
        tbl[15] = mkv(0, 2'd1, 1, 32'h10,        32'h0,         5'd16, 32'h0000_99EF, 0, 2);
        tbl[16] = mkv(0, 2'd2, 0, 32'h10,        32'h0,         5'd31, 32'h1234_99EF, 0, 2);

        for (int i = 0; i < 128; i++) ref_bytes[i] = 8'h0;
        RSTn = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;

        // Reset values while reset is held.
        repeat (3) @(negedge CLK);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_rd",    32'(rsp_rd),    32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_din",   mem_din,        32'h0);
        chk("rst_mem_wr_n",  32'(mem_wr_n),  32'h1);
        chk("rst_mem_rd_n",  32'(mem_rd_n),  32'h1);
        mem_clr = 1'b0;
        RSTn = 1'b1;
        @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // Directed vectors from the table.
        for (int i = 0; i < 17; i++) begin
            issue(tbl[i], lat, rdata, err, rd, strobe, post_valid, post_rdata);
            model(tbl[i], m_rdata, m_err, m_lat);
            chk($sformatf("tbl%0d_lat", i),    32'(lat),        32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_rdata", i),  rdata,           tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i),    32'(err),        32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_rd", i),     32'(rd),         32'(tbl[i].rd));
            chk($sformatf("tbl%0d_strobe", i), 32'(strobe),     32'(!tbl[i].exp_err));
            chk($sformatf("tbl%0d_pulse", i),  32'(post_valid), 32'h0);
            chk($sformatf("tbl%0d_hold", i),   post_rdata,      tbl[i].exp_rdata);
        end
        chk("tbl_word4", mem[4], 32'h1234_99EF);

        // Back-to-back: req_valid stays high across two stores.
        @(negedge CLK);
        chk("b2b_ready_a", 32'(req_ready), 32'h1);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_rd = 5'd20;
        req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_size = 2'd0; req_addr = 32'h25; req_wdata = 32'h0000_0077; req_rd = 5'd9;
        @(negedge CLK);
        chk("b2b_a_write_ready", 32'(req_ready), 32'h0);
        chk("b2b_a_wr_n",        32'(mem_wr_n),  32'h0);
        @(negedge CLK);
        chk("b2b_a_rsp",         32'(rsp_valid), 32'h1);
        chk("b2b_a_rsp_ready",   32'(req_ready), 32'h0);
        @(negedge CLK);
        chk("b2b_b_accept_rdy",  32'(req_ready), 32'h1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_b_read_ready",  32'(req_ready), 32'h0);
        chk("b2b_b_rd_n",        32'(mem_rd_n),  32'h0);
        @(negedge CLK);
        chk("b2b_b_write_ready", 32'(req_ready), 32'h0);
        @(negedge CLK);
        chk("b2b_b_rsp",         32'(rsp_valid), 32'h1);
        chk("b2b_b_rsp_ready",   32'(req_ready), 32'h0);
        chk("b2b_b_rsp_rd",      32'(rsp_rd),    32'd9);
        @(negedge CLK);
        chk("b2b_idle_ready",    32'(req_ready), 32'h1);
        chk("b2b_word8", mem[8], 32'hCAFE_F00D);
        chk("b2b_word9", mem[9], 32'h0000_7700);
        model(mkv(1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 5'd20, 32'h0, 0, 2), m_rdata, m_err, m_lat);
        model(mkv(1, 2'd0, 0, 32'h25, 32'h0000_0077, 5'd9,  32'h0, 0, 3), m_rdata, m_err, m_lat);

        // Async reset while a byte store to word 4 is in WRITE.
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000_00AB; req_rd = 5'd7;
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("abort_read_strobe",  32'(mem_rd_n), 32'h0);
        @(negedge CLK);
        chk("abort_write_strobe", 32'(mem_wr_n), 32'h0);
        RSTn = 1'b0;
        #1;
        chk("abort_wr_n",      32'(mem_wr_n),  32'h1);
        chk("abort_rd_n",      32'(mem_rd_n),  32'h1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort_rsp_rdata", rsp_rdata,      32'h0);
        chk("abort_rsp_rd",    32'(rsp_rd),    32'h0);
        chk("abort_rsp_err",   32'(rsp_err),   32'h0);
        chk("abort_mem_addr",  32'(mem_addr),  32'h0);
        chk("abort_mem_din",   mem_din,        32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        chk("abort_word4", mem[4], 32'h1234_99EF);
        r = mkv(0, 2'd2, 0, 32'h10, 32'h0, 5'd17, 32'h1234_99EF, 0, 2);
        issue(r, lat, rdata, err, rd, strobe, post_valid, post_rdata);
        chk("abort_next_lat",   32'(lat), 32'd2);
        chk("abort_next_rdata", rdata,    32'h1234_99EF);
        chk("abort_next_rd",    32'(rd),  32'd17);

        // Random requests against the reference model.
        for (int k = 0; k < 80; k++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.size  = 2'($urandom_range(0, 3));
            r.uns   = 1'($urandom_range(0, 1));
            r.addr  = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (r.size == 2'd1) r.addr[0] = 1'b0;
                if (r.size == 2'd2) r.addr[1:0] = 2'b00;
            end
            r.wdata = $urandom();
            r.rd    = 5'($urandom_range(0, 31));
            model(r, m_rdata, m_err, m_lat);
            issue(r, lat, rdata, err, rd, strobe, post_valid, post_rdata);
            chk($sformatf("rnd%0d_lat", k),   32'(lat),        32'(m_lat));
            chk($sformatf("rnd%0d_rdata", k), rdata,           m_rdata);
            chk($sformatf("rnd%0d_err", k),   32'(err),        32'(m_err));
            chk($sformatf("rnd%0d_rd", k),    32'(rd),         32'(r.rd));
            chk($sformatf("rnd%0d_pulse", k), 32'(post_valid), 32'h0);
            chk($sformatf("rnd%0d_hold", k),  post_rdata,      m_rdata);
        end

        // Whole memory image against the reference bytes.
        bad = 0;
        for (int w = 0; w < 32; w++) begin
            if (mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]})
                bad++;
        end
        chk("mem_image_bad_words", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
